// File: rtl/syn_fifo_v3_if.sv
// rtl/syn_fifo_v3_if.sv - write/read handshake and status bundle for syn_fifo_v3
interface syn_fifo_v3_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16
);
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  underflow;

  // Producer/consumer side
  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  // FIFO side
  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/syn_fifo_v3.sv
// rtl/syn_fifo_v3.sv - single-clock FIFO with standard/FWFT read, level and error pulses
module syn_fifo_v3 #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input logic         clk,
  input logic         rst,
  syn_fifo_v3_if.slave fifo
);
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int PW         = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH:0] LVL_ONE  = PW'(1);
  localparam logic [ADDR_WIDTH:0] LVL_FULL = PW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_TH    = PW'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_TH    = PW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   level_q;
  logic [ADDR_WIDTH:0]   level_nxt;
  logic                  full_q;
  logic                  empty_q;
  logic                  af_q;
  logic                  ae_q;
  logic                  ovf_q;
  logic                  unf_q;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance uses the registered flags, so a full FIFO still frees a slot
  // this cycle but cannot take the simultaneous write.
  assign wr_acc = fifo.wr_en && !full_q;
  assign rd_acc = fifo.rd_en && !empty_q;

  // Next-state occupancy; every status flag is registered from this value
  always_comb begin
    level_nxt = level_q;
    if (wr_acc && !rd_acc) begin
      level_nxt = level_q + LVL_ONE;
    end else if (!wr_acc && rd_acc) begin
      level_nxt = level_q - LVL_ONE;
    end
  end

  // Pointers, occupancy, flags and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + LVL_ONE;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + LVL_ONE;
      end
      level_q <= level_nxt;
      full_q  <= (level_nxt == LVL_FULL);
      empty_q <= (level_nxt == '0);
      af_q    <= (level_nxt >= AF_TH);
      ae_q    <= (level_nxt <= AE_TH);
      ovf_q   <= fifo.wr_en && full_q;
      unf_q   <= fifo.rd_en && empty_q;
    end
  end

  // Storage array; not reset, and writes are blocked in the reset cycle
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= fifo.wr_data;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign fifo.rd_data  = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign fifo.rd_valid = !empty_q;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // Registered read port: data loads on accept, valid is a one-cycle pulse
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) begin
          rd_data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
      end
    end

    assign fifo.rd_data  = rd_data_q;
    assign fifo.rd_valid = rd_valid_q;
  end

  assign fifo.full         = full_q;
  assign fifo.empty        = empty_q;
  assign fifo.almost_full  = af_q;
  assign fifo.almost_empty = ae_q;
  assign fifo.level        = level_q;
  assign fifo.overflow     = ovf_q;
  assign fifo.underflow    = unf_q;
endmodule

// File: tb/tb_syn_fifo_v3.sv
// tb/tb_syn_fifo_v3.sv - self-checking bench for syn_fifo_v3 in standard and FWFT modes
module tb_syn_fifo_v3;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic clk;
  logic rst;

  syn_fifo_v3_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) f0 ();
  syn_fifo_v3_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) f1 ();

  syn_fifo_v3 #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
    .clk  (clk),
    .rst  (rst),
    .fifo (f0.slave)
  );

  syn_fifo_v3 #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
    .clk  (clk),
    .rst  (rst),
    .fifo (f1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a queue plus what the standard read port shows
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_std_data;
  bit            exp_std_valid;
  bit            exp_ovf;
  bit            exp_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int n;
    n = q.size();
    chk("std_level", 32'(f0.level), n);
    chk("std_full", 32'(f0.full), 32'(n == DEPTH));
    chk("std_empty", 32'(f0.empty), 32'(n == 0));
    chk("std_af", 32'(f0.almost_full), 32'(n >= AF));
    chk("std_ae", 32'(f0.almost_empty), 32'(n <= AE));
    chk("std_ovf", 32'(f0.overflow), 32'(exp_ovf));
    chk("std_unf", 32'(f0.underflow), 32'(exp_unf));
    chk("std_rd_valid", 32'(f0.rd_valid), 32'(exp_std_valid));
    chk("std_rd_data", 32'(f0.rd_data), 32'(exp_std_data));
    chk("fwft_level", 32'(f1.level), n);
    chk("fwft_full", 32'(f1.full), 32'(n == DEPTH));
    chk("fwft_empty", 32'(f1.empty), 32'(n == 0));
    chk("fwft_af", 32'(f1.almost_full), 32'(n >= AF));
    chk("fwft_ae", 32'(f1.almost_empty), 32'(n <= AE));
    chk("fwft_ovf", 32'(f1.overflow), 32'(exp_ovf));
    chk("fwft_unf", 32'(f1.underflow), 32'(exp_unf));
    chk("fwft_rd_valid", 32'(f1.rd_valid), 32'(n > 0));
    if (n > 0) begin
      chk("fwft_rd_data", 32'(f1.rd_data), 32'(q[0]));
    end
  endtask

  // One clock: drive both FIFOs identically, advance the model, compare
  task automatic cyc(input bit r, input bit w, input logic [DW-1:0] d, input bit rd);
    int n;
    rst        = r;
    f0.wr_en   = w;
    f1.wr_en   = w;
    f0.wr_data = d;
    f1.wr_data = d;
    f0.rd_en   = rd;
    f1.rd_en   = rd;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      exp_std_data  = '0;
      exp_std_valid = 1'b0;
      exp_ovf       = 1'b0;
      exp_unf       = 1'b0;
    end else begin
      n             = q.size();
      exp_ovf       = w && (n == DEPTH);
      exp_unf       = rd && (n == 0);
      exp_std_valid = rd && (n > 0);
      if (exp_std_valid) begin
        exp_std_data = q.pop_front();
      end
      if (w && (n < DEPTH)) begin
        q.push_back(d);
      end
    end
    check_state();
  endtask

  initial begin
    int wb;
    int rb;
    rst = 1'b1;
    f0.wr_en = 1'b0; f1.wr_en = 1'b0;
    f0.rd_en = 1'b0; f1.rd_en = 1'b0;
    f0.wr_data = '0; f1.wr_data = '0;

    // Reset then idle
    cyc(1, 0, 16'h0, 0);
    cyc(0, 0, 16'h0, 0);
    chk("reset_empty", 32'(f0.empty), 1);
    chk("reset_ae", 32'(f0.almost_empty), 1);
    chk("reset_level", 32'(f0.level), 0);
    chk("reset_rd_data", 32'(f0.rd_data), 0);

    // Fill to capacity, then one rejected write
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(0, 1, DW'(i), 0);
      if (i == AF - 1) chk("af_below", 32'(f0.almost_full), 0);
      if (i == AF)     chk("af_at", 32'(f0.almost_full), 1);
      if (i == DEPTH - 1) chk("not_full_15", 32'(f0.full), 0);
    end
    chk("full_at16", 32'(f0.full), 1);
    cyc(0, 1, 16'hFFFF, 0);
    chk("ovf_pulse", 32'(f0.overflow), 1);
    chk("level_16", 32'(f0.level), DEPTH);
    cyc(0, 0, 16'h0, 0);
    chk("ovf_single", 32'(f0.overflow), 0);

    // Drain in order, then one rejected read
    for (int i = 1; i <= DEPTH; i++) begin
      cyc(0, 0, 16'h0, 1);
      chk("drain_valid", 32'(f0.rd_valid), 1);
      chk("drain_data", 32'(f0.rd_data), i);
    end
    chk("empty_after_drain", 32'(f0.empty), 1);
    cyc(0, 0, 16'h0, 1);
    chk("unf_pulse", 32'(f0.underflow), 1);
    chk("unf_no_valid", 32'(f0.rd_valid), 0);
    cyc(0, 0, 16'h0, 0);

    // Steady level 8 with simultaneous traffic across pointer wraps
    for (int i = 0; i < 8; i++) cyc(0, 1, DW'(16'h0100 + i), 0);
    for (int i = 8; i < 48; i++) begin
      cyc(0, 1, DW'(16'h0100 + i), 1);
      chk("steady_level", 32'(f0.level), 8);
    end
    for (int i = 0; i < 8; i++) cyc(0, 0, 16'h0, 1);

    // FWFT fall-through of a single word, then pop
    cyc(0, 1, 16'hA5A5, 0);
    chk("fwft_show_valid", 32'(f1.rd_valid), 1);
    chk("fwft_show_data", 32'(f1.rd_data), 32'h0000A5A5);
    cyc(0, 0, 16'h0, 1);
    chk("fwft_pop_valid", 32'(f1.rd_valid), 0);
    chk("fwft_pop_empty", 32'(f1.empty), 1);

    // Reset mid-operation at level 10 with both requests active
    for (int i = 0; i < 10; i++) cyc(0, 1, DW'(16'h0200 + i), 0);
    cyc(1, 1, 16'hBEEF, 1);
    chk("mid_rst_level", 32'(f0.level), 0);
    chk("mid_rst_empty", 32'(f1.empty), 1);
    chk("mid_rst_full", 32'(f0.full), 0);
    chk("mid_rst_valid_std", 32'(f0.rd_valid), 0);
    chk("mid_rst_valid_fwft", 32'(f1.rd_valid), 0);
    cyc(0, 1, 16'h1234, 0);
    chk("post_rst_fwft_data", 32'(f1.rd_data), 32'h00001234);
    cyc(0, 0, 16'h0, 1);
    chk("post_rst_std_data", 32'(f0.rd_data), 32'h00001234);

    // Randomized traffic with phase-varying bias to reach both full and empty
    for (int i = 0; i < 1600; i++) begin
      case ((i / 200) % 4)
        0: begin wb = 80; rb = 30; end
        1: begin wb = 30; rb = 80; end
        2: begin wb = 60; rb = 60; end
        default: begin wb = 95; rb = 10; end
      endcase
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 99) < wb),
          DW'($urandom),
          ($urandom_range(0, 99) < rb));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
